// File: rtl/uart_tx_frame_shifter.sv
// UART TX frame serialiser.
// Builds start/data/parity/stop frame and shifts it out per baud tick.
module uart_tx_frame_shifter #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 shift,
  output logic                 data_out,
  output logic                 ready,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int PAR_BITS  = (PARITY != 0) ? 1 : 0;
  localparam int FRAME_LEN = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;

  logic [FRAME_LEN-1:0] frame_new;
  logic                 par_bit;

  // Assemble the frame to load: stops high, parity, data, start low.
  always_comb begin
    par_bit   = (PARITY == 2) ? ~^data_in : ^data_in;
    frame_new = '1;
    frame_new[0] = 1'b0;
    frame_new[DATA_BITS:1] = data_in;
    if (PARITY != 0) begin
      frame_new[DATA_BITS+1] = par_bit;
    end
  end

  // State, frame shifter, bit counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state: load from idle, shift per tick, return after last stop.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          frame_d = frame_new;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift) begin
          frame_d = {1'b1, frame_q[FRAME_LEN-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line idles high; handshake flags follow the state.
  always_comb begin
    data_out   = (state_q == SHIFT) ? frame_q[0] : 1'b1;
    ready      = (state_q == IDLE);
    busy       = (state_q == SHIFT);
    frame_done = done_q;
  end

endmodule

// File: tb/tb_uart_tx_frame_shifter.sv
// Testbench for uart_tx_frame_shifter.
// Three configurations: 8N1, 8E2, 8O1.
module tb_uart_tx_frame_shifter;

  localparam int PARV[3] = '{0, 1, 2};
  localparam int STPV[3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic       ld[3];
  logic       sh[3];
  logic [7:0] din[3];
  logic       dout[3];
  logic       rdy[3];
  logic       bsy[3];
  logic       fd[3];

  int cmp_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  uart_tx_frame_shifter #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .load(ld[0]), .data_in(din[0]),
    .shift(sh[0]), .data_out(dout[0]), .ready(rdy[0]),
    .busy(bsy[0]), .frame_done(fd[0]));

  uart_tx_frame_shifter #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .load(ld[1]), .data_in(din[1]),
    .shift(sh[1]), .data_out(dout[1]), .ready(rdy[1]),
    .busy(bsy[1]), .frame_done(fd[1]));

  uart_tx_frame_shifter #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .load(ld[2]), .data_in(din[2]),
    .shift(sh[2]), .data_out(dout[2]), .ready(rdy[2]),
    .busy(bsy[2]), .frame_done(fd[2]));

  // Reference: expected line levels, in transmission order.
  function automatic int build(int u, logic [7:0] d, output bit b[13]);
    int n;
    int ones;
    for (int k = 0; k < 13; k++) b[k] = 1'b1;
    n = 0;
    b[n] = 1'b0;
    n = n + 1;
    for (int k = 0; k < 8; k++) begin
      b[n] = d[k];
      n = n + 1;
    end
    if (PARV[u] != 0) begin
      ones = $countones(d);
      b[n] = (PARV[u] == 1) ? bit'(ones % 2) : bit'(1 - ones % 2);
      n = n + 1;
    end
    for (int s = 0; s < STPV[u]; s++) begin
      b[n] = 1'b1;
      n = n + 1;
    end
    return n;
  endfunction

  task automatic chk(string tag, int u, logic obs, logic exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s u%0d: observed %b expected %b", tag, u, obs, exp);
    end
  endtask

  task automatic tick(int u);
    sh[u] = 1'b1;
    @(negedge clk);
    sh[u] = 1'b0;
  endtask

  // Send one frame on unit u. Caller is at a negedge.
  task automatic send(int u, logic [7:0] d, bit with_sh,
                      int intrude_at, int abort_at);
    bit b[13];
    int n;
    int g;
    n = build(u, d, b);
    ld[u]  = 1'b1;
    din[u] = d;
    sh[u]  = with_sh;
    @(negedge clk);
    ld[u]  = 1'b0;
    sh[u]  = 1'b0;
    din[u] = 8'($urandom);
    chk("start", u, dout[u], 1'b0);
    chk("busy", u, bsy[u], 1'b1);
    chk("nrdy", u, rdy[u], 1'b0);
    for (int i = 1; i <= n; i++) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(negedge clk);
        chk("hold", u, dout[u], b[i-1]);
      end
      if (i == intrude_at) begin
        ld[u]  = 1'b1;
        din[u] = 8'hF0;
        @(negedge clk);
        ld[u]  = 1'b0;
        chk("ignld", u, dout[u], b[i-1]);
        chk("ignbsy", u, bsy[u], 1'b1);
      end
      tick(u);
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_out", u, dout[u], 1'b1);
        chk("rst_rdy", u, rdy[u], 1'b1);
        chk("rst_fd", u, fd[u], 1'b0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_nofd", u, fd[u], 1'b0);
          chk("rst_idle", u, dout[u], 1'b1);
        end
        return;
      end
      if (i < n) begin
        chk("bit", u, dout[u], b[i]);
        chk("nofd", u, fd[u], 1'b0);
        chk("midrdy", u, rdy[u], 1'b0);
      end else begin
        chk("done", u, fd[u], 1'b1);
        chk("endrdy", u, rdy[u], 1'b1);
        chk("endbsy", u, bsy[u], 1'b0);
        chk("endout", u, dout[u], 1'b1);
      end
    end
  endtask

  task automatic settle(int u);
    @(negedge clk);
    chk("fdpulse", u, fd[u], 1'b0);
    chk("idle", u, dout[u], 1'b1);
    chk("idlerdy", u, rdy[u], 1'b1);
  endtask

  initial begin
    int u;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld[k]  = 1'b0;
      sh[k]  = 1'b0;
      din[k] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rs_out", k, dout[k], 1'b1);
      chk("rs_rdy", k, rdy[k], 1'b1);
      chk("rs_bsy", k, bsy[k], 1'b0);
      chk("rs_fd", k, fd[k], 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);

    send(0, 8'h55, 1'b0, 0, 0);
    settle(0);
    send(1, 8'h07, 1'b0, 0, 0);
    settle(1);
    send(2, 8'h07, 1'b0, 0, 0);
    settle(2);
    send(1, 8'hA3, 1'b0, 0, 0);
    settle(1);
    send(0, 8'h0F, 1'b0, 3, 0);
    settle(0);
    send(0, 8'h0F, 1'b0, 0, 0);
    send(0, 8'hF0, 1'b0, 0, 0);
    settle(0);
    send(1, 8'h3C, 1'b0, 0, 4);
    send(1, 8'h5A, 1'b0, 0, 0);
    settle(1);

    tick(0);
    chk("idlesh", 0, dout[0], 1'b1);
    chk("idleshr", 0, rdy[0], 1'b1);
    send(0, 8'h55, 1'b1, 0, 0);
    settle(0);

    for (int r = 0; r < 30; r++) begin
      u = int'($urandom_range(0, 2));
      send(u, 8'($urandom), 1'($urandom), 0, 0);
      if ($urandom_range(0, 1) == 0) begin
        send(u, 8'($urandom), 1'b0,
             int'($urandom_range(0, 6)), 0);
      end
      settle(u);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule
